mux_scan: RTL and testbench
===========================

MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each data channel.
REQ-002 Parameter CHANNELS, default 4: number of input channels, 2..16, power of two not required.
REQ-003 Parameter DIV, default 100000: clock cycles per scan step in auto mode, >= 1.
REQ-004 Derived SELW = max(1, ceil(log2(CHANNELS))).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 data_in  input  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH].
REQ-009 mode  input  1  0 = manual (sel drives channel), 1 = auto round-robin scan.
REQ-010 sel  input  SELW  channel request, used in manual mode only.
REQ-011 hold  input  1  freezes channel index and prescaler while high.
REQ-012 out  output  WIDTH  registered selected channel data.
REQ-013 ch  output  SELW  registered current channel index.
REQ-014 ch_onehot  output  CHANNELS  registered one-hot of ch (display digit enable); all zeros when invalid.
REQ-015 step  output  1  one-cycle pulse, high in the cycle after ch advanced in auto mode.

Function
REQ-016 Prescaler: counter 0..DIV-1, increments each cycle when mode=1 and hold=0; wraps to 0 after DIV-1.
REQ-017 Auto step: when the prescaler is DIV-1, mode=1 and hold=0, ch SHALL advance ch+1, wrapping CHANNELS-1 -> 0.
REQ-018 With DIV=1, ch SHALL advance every enabled cycle.
REQ-019 Manual: when mode=0 and hold=0, ch SHALL load sel on the next edge; prescaler held at 0.
REQ-020 Latency: out and ch_onehot SHALL reflect the ch value registered on the same edge (out = channel ch of data_in sampled on that edge), i.e. one cycle from sel/data_in change to out.
REQ-021 data_in changes SHALL propagate to out one cycle later even while hold=1 or ch is unchanged.
REQ-022 Invalid index: if manual sel >= CHANNELS, ch SHALL load sel, out SHALL be all ones, ch_onehot SHALL be all zeros.
REQ-023 hold=1 SHALL override mode; ch and prescaler keep value; step stays 0.
REQ-024 Mode switch 0->1: scanning starts from current ch (wrapping to 0 first if ch is invalid), prescaler starts at 0.
REQ-025 Mode switch 1->0: ch loads sel on that edge; any partial prescaler count discarded.
REQ-026 step SHALL be 0 in manual mode and during hold.

Reset
REQ-027 While rst_n=0: ch=0, prescaler=0, out=0, ch_onehot=0, step=0, regardless of clk.
REQ-028 Reset assertion mid-scan SHALL take effect immediately; after release, the first edge loads ch per mode and updates out and ch_onehot normally.
REQ-029 No output SHALL be X after reset with known inputs.

Verification (WIDTH=4, CHANNELS=4, DIV=3 unless stated)
REQ-030 Manual: mode=0, data_in=16'hDCBA, sel=2 -> next edge out=4'hC, ch=2, ch_onehot=4'b0100, step=0.
REQ-031 Auto wrap: mode=1 from ch=3, prescaler=0 -> after 3 edges ch=0, out=4'hA, ch_onehot=4'b0001, step high one cycle; full sequence 3,0,1,2,3 over 12 cycles.
REQ-032 Hold: mode=1, hold=1 for 10 cycles -> ch constant, step=0; data_in change 4'hA->4'h5 on ch 0 appears on out one cycle later.
REQ-033 Invalid index (CHANNELS=3, SELW=2): mode=0, sel=3 -> out=4'hF, ch_onehot=3'b000; then mode=1 -> first step to ch=0.
REQ-034 Async reset: assert rst_n=0 between edges mid-scan -> out=0, ch=0, ch_onehot=0 without a clock edge; release -> normal operation from ch=0.
REQ-035 DIV=1: mode=1 -> ch advances every cycle, step high every cycle after the first advance.

Source files
------------

// File: rtl/mux_scan.sv
// Channel multiplexer with manual select and prescaled round-robin auto scan.
// All outputs are registered; out/ch_onehot follow the ch value loaded on the same edge.
module mux_scan #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV      = 100000,
  localparam int unsigned SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SELW-1:0]           ch,
  output logic [CHANNELS-1:0]       ch_onehot,
  output logic                      step
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [SELW-1:0]     ch_q, ch_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic                step_q, step_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [CHANNELS-1:0] onehot_q, onehot_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q     <= '0;
      pre_q    <= '0;
      step_q   <= 1'b0;
      out_q    <= '0;
      onehot_q <= '0;
    end else begin
      ch_q     <= ch_d;
      pre_q    <= pre_d;
      step_q   <= step_d;
      out_q    <= out_d;
      onehot_q <= onehot_d;
    end
  end

  // Next channel/prescaler, then decode of the channel being loaded this edge
  always_comb begin
    ch_d     = ch_q;
    pre_d    = pre_q;
    step_d   = 1'b0;
    out_d    = '1;
    onehot_d = '0;

    if (!hold) begin
      if (!mode) begin
        ch_d  = sel;
        pre_d = '0;
      end else if (pre_q == PW'(DIV - 1)) begin
        pre_d  = '0;
        step_d = 1'b1;
        // An out-of-range index also wraps to channel 0
        ch_d   = (ch_q >= SELW'(CHANNELS - 1)) ? '0 : ch_q + SELW'(1);
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ch_d == SELW'(k)) begin
        out_d       = data_in[k*WIDTH +: WIDTH];
        onehot_d[k] = 1'b1;
      end
    end
  end

  assign out       = out_q;
  assign ch        = ch_q;
  assign ch_onehot = onehot_q;
  assign step      = step_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three configurations (4ch/DIV3, 3ch/DIV3, 4ch/DIV1) against a scan model.
module tb_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        mode = 1'b0, hold = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] din4 = 16'h0;
  logic [11:0] din3 = 12'h0;

  logic [3:0] out0, out1, out2;
  logic [1:0] ch0, ch1, ch2;
  logic [3:0] oh0, oh2;
  logic [2:0] oh1;
  logic       st0, st1, st2;

  int checks = 0;
  int errors = 0;

  mux_scan #(.WIDTH(4), .CHANNELS(4), .DIV(3)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(din4), .mode(mode), .sel(sel), .hold(hold),
    .out(out0), .ch(ch0), .ch_onehot(oh0), .step(st0));
  mux_scan #(.WIDTH(4), .CHANNELS(3), .DIV(3)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(din3), .mode(mode), .sel(sel), .hold(hold),
    .out(out1), .ch(ch1), .ch_onehot(oh1), .step(st1));
  mux_scan #(.WIDTH(4), .CHANNELS(4), .DIV(1)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(din4), .mode(mode), .sel(sel), .hold(hold),
    .out(out2), .ch(ch2), .ch_onehot(oh2), .step(st2));

  // Reference: index/count as integers, outputs derived arithmetically
  int cfg_c [3] = '{4, 3, 4};
  int cfg_d [3] = '{3, 3, 1};
  int m_ch [3], m_pre [3], m_step [3], m_out [3], m_oh [3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ch[i] = 0; m_pre[i] = 0; m_step[i] = 0; m_out[i] = 0; m_oh[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    int data;
    for (int i = 0; i < 3; i++) begin
      data = (i == 1) ? int'(din3) : int'(din4);
      m_step[i] = 0;
      if (!hold) begin
        if (!mode) begin
          m_ch[i] = int'(sel);
          m_pre[i] = 0;
        end else if (m_pre[i] + 1 == cfg_d[i]) begin
          m_pre[i] = 0;
          m_step[i] = 1;
          m_ch[i] = (m_ch[i] + 1 >= cfg_c[i]) ? 0 : m_ch[i] + 1;
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
      end
      if (m_ch[i] < cfg_c[i]) begin
        m_out[i] = (data >> (4 * m_ch[i])) % 16;
        m_oh[i] = 1 << m_ch[i];
      end else begin
        m_out[i] = 15;
        m_oh[i] = 0;
      end
    end
  endfunction

  function automatic logic [15:0] expv(int i);
    logic [3:0] o; logic [1:0] c; logic [3:0] h; logic s;
    o = m_out[i][3:0]; c = m_ch[i][1:0]; h = m_oh[i][3:0]; s = m_step[i][0];
    if (i == 1) return 16'({o, c, h[2:0], s});
    return 16'({o, c, h, s});
  endfunction

  function automatic logic [15:0] actv(int i);
    if (i == 0) return 16'({out0, ch0, oh0, st0});
    if (i == 1) return 16'({out1, ch1, oh1, st1});
    return 16'({out2, ch2, oh2, st2});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (actv(i) !== 16'h0) begin
        errors++; $display("FAIL reset inst%0d got %h exp 0000", i, actv(i));
      end
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    mode = 1'b0; hold = 1'b0; din4 = 16'hDCBA; sel = 2'd2;
    tick();
    checks++;
    if ({out0, ch0, oh0, st0} !== {4'hC, 2'd2, 4'b0100, 1'b0}) begin
      errors++; $display("FAIL manual_sel2 got %h/%0d/%b/%b exp c/2/0100/0", out0, ch0, oh0, st0);
    end
    for (int n = 0; n < 20; n++) begin
      sel = 2'($urandom_range(0, 3)); din4 = 16'($urandom); din3 = 12'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) begin
          errors++; $display("FAIL manual_rand inst%0d got %h exp %h", i, actv(i), expv(i));
        end
      end
    end
  endtask

  task automatic test_auto_wrap();
    int seq [12] = '{3, 3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
    mode = 1'b0; hold = 1'b0; sel = 2'd3; din4 = 16'hDCBA;
    tick();
    mode = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      checks++;
      if (ch0 !== 2'(seq[n]) || st0 !== (n % 3 == 2)) begin
        errors++; $display("FAIL auto_seq edge%0d got ch=%0d step=%b exp ch=%0d", n + 1, ch0, st0, seq[n]);
      end
      if (n == 2) begin
        checks++;
        if ({out0, oh0} !== {4'hA, 4'b0001}) begin
          errors++; $display("FAIL auto_wrap got out=%h oh=%b exp a/0001", out0, oh0);
        end
      end
      checks++;
      if (actv(0) !== expv(0)) begin
        errors++; $display("FAIL auto_model got %h exp %h", actv(0), expv(0));
      end
    end
  endtask

  task automatic test_hold();
    mode = 1'b0; hold = 1'b0; sel = 2'd0; din4 = 16'hDCBA;
    tick();
    mode = 1'b1; hold = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (n == 5) din4 = 16'hDCB5;
      tick();
      checks++;
      if (ch0 !== 2'd0 || st0 !== 1'b0 || out0 !== ((n >= 5) ? 4'h5 : 4'hA)) begin
        errors++; $display("FAIL hold cyc%0d got ch=%0d step=%b out=%h", n, ch0, st0, out0);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) begin
          errors++; $display("FAIL hold_model inst%0d got %h exp %h", i, actv(i), expv(i));
        end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_invalid();
    mode = 1'b0; hold = 1'b0; sel = 2'd3; din3 = 12'h321;
    tick();
    checks++;
    if ({out1, ch1, oh1} !== {4'hF, 2'd3, 3'b000}) begin
      errors++; $display("FAIL invalid got out=%h ch=%0d oh=%b exp f/3/000", out1, ch1, oh1);
    end
    mode = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    checks++;
    if ({out1, ch1, oh1, st1} !== {4'h1, 2'd0, 3'b001, 1'b1}) begin
      errors++; $display("FAIL invalid_wrap got out=%h ch=%0d oh=%b step=%b exp 1/0/001/1", out1, ch1, oh1, st1);
    end
  endtask

  task automatic test_div1();
    int seq [5] = '{2, 3, 0, 1, 2};
    mode = 1'b0; hold = 1'b0; sel = 2'd1;
    tick();
    mode = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (ch2 !== 2'(seq[n]) || st2 !== 1'b1) begin
        errors++; $display("FAIL div1 cyc%0d got ch=%0d step=%b exp ch=%0d step=1", n, ch2, st2, seq[n]);
      end
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; hold = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (actv(i) !== 16'h0) begin
        errors++; $display("FAIL async_reset inst%0d got %h exp 0000", i, actv(i));
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) begin
          errors++; $display("FAIL post_reset inst%0d got %h exp %h", i, actv(i), expv(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      hold = ($urandom_range(0, 4) == 0);
      sel  = 2'($urandom_range(0, 3));
      din4 = 16'($urandom); din3 = 12'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) begin
          errors++; $display("FAIL random n%0d inst%0d got %h exp %h", n, i, actv(i), expv(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_wrap();
    test_hold();
    test_invalid();
    test_div1();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
